// File: rtl/lcd_status_writer.sv
// lcd_status_writer: HD44780 8-bit write-only driver; runs the LCD power-up/init
//   sequence, then on request writes a 2x16 status frame (hunger, health, face code).
// Ports: clk, rst (sync active-high), start, hunger[2:0], health[2:0], face_code[2:0],
//   busy, rs, rw (always 0), data[7:0], enable.
module lcd_status_writer #(
  parameter int T_POWERUP = 750000,
  parameter int T_EN      = 25,
  parameter int T_CMD     = 2500,
  parameter int T_CLEAR   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] hunger,
  input  logic [2:0] health,
  input  logic [2:0] face_code,
  output logic       busy,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data,
  output logic       enable
);

  localparam int MAX_A = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXP + 1);

  // Counters count down to zero, so each load value is the duration minus one.
  localparam logic [CW-1:0] LD_POWERUP = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] LD_EN      = CW'(T_EN - 1);
  localparam logic [CW-1:0] LD_CMD     = CW'(T_CMD - 1);
  localparam logic [CW-1:0] LD_CLEAR   = CW'(T_CLEAR - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;

  localparam logic [5:0] INIT_LAST  = 6'd3;
  localparam logic [5:0] FRAME_LAST = 6'd33;

  typedef enum logic [1:0] {ST_POWERUP, ST_INIT, ST_IDLE, ST_FRAME} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0]    idx, idx_n;
  logic          pending;
  logic          latch_vals;
  logic [2:0]    hunger_q, health_q, face_q;

  logic [7:0]    cur_byte;
  logic          cur_is_char;
  logic          is_clear;
  logic          go_frame;

  // Byte currently being transferred; a pure function of state/idx/latched values,
  // so it cannot change within a SETUP..HOLD window.
  always_comb begin
    cur_byte    = 8'h00;
    cur_is_char = 1'b0;
    if (state == ST_INIT) begin
      case (idx)
        6'd0:    cur_byte = 8'h38;
        6'd1:    cur_byte = 8'h0C;
        6'd2:    cur_byte = 8'h06;
        default: cur_byte = 8'h01;
      endcase
    end else if (state == ST_FRAME) begin
      cur_is_char = (idx != 6'd0) && (idx != 6'd17);
      case (idx)
        6'd0:    cur_byte = 8'h80;
        6'd1:    cur_byte = 8'h48;
        6'd2:    cur_byte = 8'h41;
        6'd3:    cur_byte = 8'h4D;
        6'd4:    cur_byte = 8'h42;
        6'd5:    cur_byte = 8'h52;
        6'd6:    cur_byte = 8'h45;
        6'd7:    cur_byte = 8'h3A;
        6'd8:    cur_byte = {5'b00110, hunger_q};
        6'd9:    cur_byte = 8'h20;
        6'd10:   cur_byte = 8'h53;
        6'd11:   cur_byte = 8'h41;
        6'd12:   cur_byte = 8'h4C;
        6'd13:   cur_byte = 8'h55;
        6'd14:   cur_byte = 8'h44;
        6'd15:   cur_byte = 8'h3A;
        6'd16:   cur_byte = {5'b00110, health_q};
        6'd17:   cur_byte = 8'hC0;
        6'd18:   cur_byte = 8'h45;
        6'd19:   cur_byte = 8'h53;
        6'd20:   cur_byte = 8'h54;
        6'd21:   cur_byte = 8'h41;
        6'd22:   cur_byte = 8'h44;
        6'd23:   cur_byte = 8'h4F;
        6'd24:   cur_byte = 8'h3A;
        6'd25:   cur_byte = {5'b00110, face_q};
        default: cur_byte = 8'h20;
      endcase
    end
  end

  assign is_clear = (state == ST_INIT) && (cur_byte == 8'h01);
  // A start arriving in the very last HOLD cycle is honoured as if already pending.
  assign go_frame = pending || start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_POWERUP;
      phase    <= PH_SETUP;
      cnt      <= LD_POWERUP;
      idx      <= 6'd0;
      pending  <= 1'b0;
      hunger_q <= 3'd0;
      health_q <= 3'd0;
      face_q   <= 3'd0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      if (latch_vals) begin
        pending  <= 1'b0;
        hunger_q <= hunger;
        health_q <= health;
        face_q   <= face_code;
      end else if (start && (state != ST_IDLE)) begin
        pending <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cnt_n      = cnt;
    idx_n      = idx;
    latch_vals = 1'b0;
    case (state)
      ST_POWERUP: begin
        if (cnt == CNT_ZERO) begin
          state_n = ST_INIT;
          phase_n = PH_SETUP;
          idx_n   = 6'd0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (start) begin
          state_n    = ST_FRAME;
          phase_n    = PH_SETUP;
          idx_n      = 6'd0;
          latch_vals = 1'b1;
        end
      end
      default: begin
        case (phase)
          PH_SETUP: begin
            phase_n = PH_PULSE;
            cnt_n   = LD_EN;
          end
          PH_PULSE: begin
            if (cnt == CNT_ZERO) begin
              phase_n = PH_HOLD;
              cnt_n   = is_clear ? LD_CLEAR : LD_CMD;
            end else begin
              cnt_n = cnt - CNT_ONE;
            end
          end
          default: begin
            if (cnt != CNT_ZERO) begin
              cnt_n = cnt - CNT_ONE;
            end else if ((state == ST_INIT && idx == INIT_LAST) ||
                         (state == ST_FRAME && idx == FRAME_LAST)) begin
              if (go_frame) begin
                state_n    = ST_FRAME;
                phase_n    = PH_SETUP;
                idx_n      = 6'd0;
                latch_vals = 1'b1;
              end else begin
                state_n = ST_IDLE;
                phase_n = PH_SETUP;
              end
            end else begin
              idx_n   = idx + 6'd1;
              phase_n = PH_SETUP;
            end
          end
        endcase
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy   = (state != ST_IDLE);
    rw     = 1'b0;
    rs     = cur_is_char;
    data   = cur_byte;
    enable = ((state == ST_INIT) || (state == ST_FRAME)) && (phase == PH_PULSE);
  end

endmodule
